// File: rtl/ddr_traffic_pkg.sv
// ddr_traffic_pkg: shared pattern/state types and LFSR helpers for DDR traffic generators
package ddr_traffic_pkg;
  typedef enum logic [1:0] {PAT_ADDR, PAT_COUNT, PAT_LFSR, PAT_TOGGLE} pattern_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic int lane_count(int data_w);
    return data_w / 32;
  endfunction
  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/ddr_pattern_lfsr.sv
// ddr_pattern_lfsr: 32-bit Galois LFSR with seed load and single-step advance
module ddr_pattern_lfsr
  import ddr_traffic_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        ui_clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] q
);
  always_ff @(posedge ui_clk or negedge rst)
    if (!rst) q <= SEED;
    else if (load) q <= SEED;
    else if (adv) q <= lfsr_step(q);
endmodule

// File: rtl/ddr_wr_traffic_gen.sv
// ddr_wr_traffic_gen: writes a programmable run of patterned words to consecutive DDR addresses
module ddr_wr_traffic_gen
  import ddr_traffic_pkg::*;
#(
  parameter int          ADDR_W    = 25,
  parameter int          DATA_W    = 256,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [1:0]        pattern_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written,
  output logic [31:0]       stall_cycles
);
  localparam int LANES = lane_count(DATA_W);
  state_e            state;
  pattern_e          pat_q;
  logic [ADDR_W-1:0] len_q;
  logic [31:0]       lfsr_q;
  logic              acc, last, load;
  assign acc  = wr_en & ~wr_busy;
  assign last = words_written + 1'b1 == len_q;
  assign load = state == IDLE && start && num_words != '0;
  assign busy = state == RUN;
  assign done = state == DONE;
  function automatic logic [DATA_W-1:0] pattern(pattern_e p, logic [ADDR_W-1:0] a,
                                                logic [ADDR_W-1:0] n, logic [31:0] l);
    logic [DATA_W-1:0] d;
    logic [31:0]       w;
    int                s;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      s = (4 * k) % 32;
      w = p == PAT_ADDR  ? {4'(k), 3'b000, 25'(a)} :
          p == PAT_COUNT ? 32'(n) :
          p == PAT_LFSR  ? (s == 0 ? l : (l << s) | (l >> (32 - s))) :
          (n[0] ? 32'h0 : 32'hFFFF_FFFF);
      d[32*k +: 32] = w;
    end
    return d;
  endfunction
  ddr_pattern_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .ui_clk(ui_clk),
    .rst   (rst),
    .load  (load),
    .adv   (busy && acc),
    .q     (lfsr_q)
  );
  always_ff @(posedge ui_clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      pat_q         <= PAT_ADDR;
      len_q         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            pat_q <= pattern_e'(pattern_sel);
            len_q <= num_words;
            state <= load ? RUN : DONE;
            if (load) begin
              wr_en         <= 1'b1;
              wr_addr       <= base_addr;
              wr_data       <= pattern(pattern_e'(pattern_sel), base_addr, '0, LFSR_SEED);
              words_written <= '0;
              stall_cycles  <= '0;
            end
          end
        RUN: begin
          if (wr_en && wr_busy && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
          if (acc) begin
            words_written <= words_written + 1'b1;
            wr_en         <= !last;
            state         <= last ? DONE : RUN;
            if (!last) begin
              wr_addr <= wr_addr + 1'b1;
              wr_data <= pattern(pat_q, wr_addr + 1'b1, words_written + 1'b1, lfsr_step(lfsr_q));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
